phy_tx_serializer: RTL and testbench



---
 rtl/phy_pkg.sv | 14 +
 rtl/lane_serializer.sv | 42 ++++
 rtl/phy_tx_serializer.sv | 59 +++++
 tb/tb_phy_tx_serializer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/phy_pkg.sv
// Shared PHY constants: frame geometry and the COM alignment symbol.
// The receive path imports the same package so both sides agree on COM.
package phy_pkg;

    localparam int unsigned FRAME_BITS = 32;
    localparam int unsigned NUM_LANES  = 2;
    localparam int unsigned CNT_W      = $clog2(FRAME_BITS);

    typedef logic [FRAME_BITS-1:0] word_t;

    localparam logic [7:0] COM       = 8'hBC;
    localparam word_t      COM_FRAME = {4{COM}};

endpackage

// File: rtl/lane_serializer.sv
// One transmit lane: a holding register for the next frame's word and a
// shift register that streams the current frame MSB first.
module lane_serializer
    import phy_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  load,
    input  logic  accept,
    input  word_t data,
    output logic  full,
    output logic  serial
);

    word_t hold;
    word_t sh;

    // At a frame boundary the held word (or COM filler) enters the shifter;
    // an accept on the same edge wins over the clear so full stays set.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold <= '0;
            full <= 1'b0;
            sh   <= COM_FRAME;
        end else begin
            if (load) begin
                sh <= full ? hold : COM_FRAME;
            end else begin
                sh <= {sh[FRAME_BITS-2:0], 1'b0};
            end
            if (accept) begin
                hold <= data;
                full <= 1'b1;
            end else if (load) begin
                full <= 1'b0;
            end
        end
    end

    assign serial = sh[FRAME_BITS-1];

endmodule

// File: rtl/phy_tx_serializer.sv
// Transmit PHY back end: stripes 32-bit words across two lanes (lane 0 first)
// and serializes each lane MSB first, with COM filler in idle frames.
module phy_tx_serializer
    import phy_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] dataIn,
    input  logic        validIn,
    output logic        readyOut,
    output logic        out_data_serie_0,
    output logic        out_data_serie_1,
    output logic        frameStart
);

    logic [CNT_W-1:0]     cnt;
    logic                 ptr;
    logic                 boundary;
    logic                 xfer;
    logic [NUM_LANES-1:0] full;
    logic [NUM_LANES-1:0] accept;
    logic [NUM_LANES-1:0] serial;

    assign boundary = (cnt == CNT_W'(FRAME_BITS - 1));
    assign readyOut = !full[ptr];
    assign xfer     = validIn && readyOut;
    assign accept   = xfer ? (NUM_LANES'(1) << ptr) : '0;

    // Bit counter, lane pointer and the registered frame marker.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            ptr        <= 1'b0;
            frameStart <= 1'b1;
        end else begin
            cnt        <= cnt + CNT_W'(1);
            frameStart <= boundary;
            if (xfer) begin
                ptr <= !ptr;
            end
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        lane_serializer u_lane (
            .clk    (clk),
            .reset  (reset),
            .load   (boundary),
            .accept (accept[g]),
            .data   (dataIn),
            .full   (full[g]),
            .serial (serial[g])
        );
    end

    assign out_data_serie_0 = serial[0];
    assign out_data_serie_1 = serial[1];

endmodule

// File: tb/tb_phy_tx_serializer.sv
// Directed bench for phy_tx_serializer: expected lane frames are queued by the
// stimulus and a free-running monitor reassembles and compares each frame.
module tb_phy_tx_serializer;

    localparam logic [31:0] C = 32'hBCBCBCBC;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] dataIn;
    logic        validIn;
    logic        readyOut;
    logic        out_data_serie_0;
    logic        out_data_serie_1;
    logic        frameStart;

    typedef struct {
        logic [31:0] l0;
        logic [31:0] l1;
    } frame_t;

    frame_t exp_q[$];
    int     tests = 0;
    int     fails = 0;
    int     tcyc  = 0;
    string  cur_test = "init";

    phy_tx_serializer dut (
        .clk              (clk),
        .reset            (reset),
        .dataIn           (dataIn),
        .validIn          (validIn),
        .readyOut         (readyOut),
        .out_data_serie_0 (out_data_serie_0),
        .out_data_serie_1 (out_data_serie_1),
        .frameStart       (frameStart)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s/%s: got %h expected %h", cur_test, name, act, req);
        end
    endtask

    task automatic push(input logic [31:0] l0, input logic [31:0] l1);
        frame_t f;
        f.l0 = l0;
        f.l1 = l1;
        exp_q.push_back(f);
    endtask

    task automatic step();
        @(negedge clk);
        tcyc++;
    endtask

    task automatic goto(input int c);
        while (tcyc < c) step();
    endtask

    // Leaves the bench at the negedge of bit 0 of frame 0.
    task automatic do_reset();
        @(negedge clk);
        reset   = 1'b1;
        validIn = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        tcyc  = 0;
    endtask

    task automatic send(input logic [31:0] d);
        dataIn  = d;
        validIn = 1'b1;
        check("ready_at_send", 32'(readyOut), 32'd1);
        step();
        validIn = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            step();
            n++;
        end
        if (exp_q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL %s/drain: %0d frames still expected after %0d cycles", cur_test, exp_q.size(), budget);
            exp_q.delete();
        end
    endtask

    // Monitor: sample just after each rising edge, rebuild 32-bit lane frames.
    initial begin : monitor
        int          bitpos;
        logic [31:0] s0;
        logic [31:0] s1;
        frame_t      f;
        bitpos = 0;
        s0 = '0;
        s1 = '0;
        forever begin
            @(posedge clk);
            #1;
            if (bitpos == 32) check("frame_start_period", 32'(frameStart), 32'd1);
            if (frameStart) bitpos = 0;
            s0 = {s0[30:0], out_data_serie_0};
            s1 = {s1[30:0], out_data_serie_1};
            bitpos++;
            if (bitpos == 32 && exp_q.size() > 0) begin
                f = exp_q.pop_front();
                check("lane0_frame", s0, f.l0);
                check("lane1_frame", s1, f.l1);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [31:0] words [3];
        int          acc [3];
        int          idx;
        int          n;

        reset   = 1'b1;
        validIn = 1'b0;
        dataIn  = '0;

        // Idle after reset: COM on both lanes, always ready.
        cur_test = "reset_idle";
        do_reset();
        check("out0_reset", 32'(out_data_serie_0), 32'd1);
        check("out1_reset", 32'(out_data_serie_1), 32'd1);
        check("frame_start_reset", 32'(frameStart), 32'd1);
        push(C, C);
        push(C, C);
        push(C, C);
        for (int i = 0; i < 96; i++) begin
            check("ready_idle", 32'(readyOut), 32'd1);
            step();
        end
        drain(64);

        cur_test = "single_word";
        do_reset();
        push(C, C);
        push(C, C);
        push(32'hDEADBEEF, C);
        push(C, C);
        goto(37);
        send(32'hDEADBEEF);
        drain(200);

        // Three words back to back: third waits for the frame-2 boundary.
        cur_test = "striping";
        do_reset();
        push(C, C);
        push(C, C);
        push(32'h11111111, 32'h22222222);
        push(32'h33333333, C);
        push(C, C);
        words[0] = 32'h11111111;
        words[1] = 32'h22222222;
        words[2] = 32'h33333333;
        for (int i = 0; i < 3; i++) acc[i] = -1;
        goto(32);
        idx = 0;
        n   = 0;
        while (idx < 3 && n < 200) begin
            dataIn  = words[idx];
            validIn = 1'b1;
            if (readyOut) begin
                acc[idx] = tcyc;
                idx++;
            end
            step();
            n++;
        end
        validIn = 1'b0;
        check("accept_cycle_w0", 32'(acc[0]), 32'd32);
        check("accept_cycle_w1", 32'(acc[1]), 32'd33);
        check("accept_cycle_w2", 32'(acc[2]), 32'd64);
        drain(200);

        cur_test = "init_frame";
        do_reset();
        push(C, C);
        push(32'hA5A5A5A5, C);
        push(C, C);
        send(32'hA5A5A5A5);
        drain(200);

        cur_test = "boundary_accept";
        do_reset();
        push(C, C);
        push(C, C);
        push(C, C);
        push(32'hCAFEF00D, C);
        push(C, C);
        goto(63);
        send(32'hCAFEF00D);
        drain(300);

        // Reset in the middle of a data frame with a further word held.
        cur_test = "reset_mid_frame";
        do_reset();
        push(C, C);
        send(32'h12345678);
        goto(40);
        send(32'h55AA55AA);
        goto(44);
        check("out0_data_bit19", 32'(out_data_serie_0), 32'd0);
        check("ready_before_reset", 32'(readyOut), 32'd1);
        reset = 1'b1;
        step();
        check("out0_after_reset", 32'(out_data_serie_0), 32'd1);
        check("out1_after_reset", 32'(out_data_serie_1), 32'd1);
        check("frame_start_after_reset", 32'(frameStart), 32'd1);
        check("ready_after_reset", 32'(readyOut), 32'd1);
        check("frames_pending_at_reset", 32'(exp_q.size()), 32'd0);
        reset = 1'b0;
        tcyc  = 0;
        push(C, C);
        push(C, C);
        drain(200);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
